// File: rtl/core_wb_arb.sv
// Two-master Wishbone arbiter: IDLE/OWN0/OWN1 FSM with bus locking and a stall timeout.
// The slave-side mux and master acks are combinational from the registered grant.
module core_wb_arb #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int TIMEOUT     = 16
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_w,
  output logic [DW-1:0] m0_dat_r,
  output logic          m0_ack,
  output logic          m0_err,

  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_w,
  output logic [DW-1:0] m1_dat_r,
  output logic          m1_ack,
  output logic          m1_err,

  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_w,
  input  logic [DW-1:0] s_dat_r,
  input  logic          s_ack,

  output logic [1:0]    gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last_owner;
  logic [7:0] stall_cnt;
  logic       own_cyc;
  logic       own_stb;
  logic       timeout;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    if (gnt[0]) begin
      own_cyc = m0_cyc;
      own_stb = m0_stb;
    end else if (gnt[1]) begin
      own_cyc = m1_cyc;
      own_stb = m1_stb;
    end
  end

  // A reset in the same cycle must abort silently, so it masks the timeout.
  assign timeout = (state != IDLE) && own_cyc && own_stb && !s_ack &&
                   (stall_cnt == STALL_LIMIT) && !rst;

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    case (gnt)
      2'b01: begin
        s_cyc   = m0_cyc;
        s_stb   = m0_stb;
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_dat_w = m0_dat_w;
      end
      2'b10: begin
        s_cyc   = m1_cyc;
        s_stb   = m1_stb;
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_dat_w = m1_dat_w;
      end
      default: ;
    endcase
  end

  assign m0_ack   = gnt[0] & m0_cyc & s_ack;
  assign m1_ack   = gnt[1] & m1_cyc & s_ack;
  assign m0_err   = gnt[0] & timeout;
  assign m1_err   = gnt[1] & timeout;
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

  // last_owner=1 after reset so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      stall_cnt  <= 8'd0;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          stall_cnt <= 8'd0;
          if (m0_cyc && m1_cyc) begin
            if (ROUND_ROBIN && last_owner) begin
              state <= OWN0;
              gnt   <= 2'b01;
            end else begin
              state <= OWN1;
              gnt   <= 2'b10;
            end
          end else if (m0_cyc) begin
            state <= OWN0;
            gnt   <= 2'b01;
          end else if (m1_cyc) begin
            state <= OWN1;
            gnt   <= 2'b10;
          end
        end
        OWN0, OWN1: begin
          if (!own_cyc || timeout) begin
            state      <= IDLE;
            gnt        <= 2'b00;
            stall_cnt  <= 8'd0;
            last_owner <= (state == OWN1);
          end else if (s_ack || !own_stb) begin
            stall_cnt <= 8'd0;
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= 2'b00;
          stall_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/core_wb_arb.md
CORE_WB_ARB -- requirements
Module: core_wb_arb

Interface
REQ-001 Parameter: AW, 32, address width.
REQ-002 Parameter: DW, 32, data width.
REQ-003 Parameter: ROUND_ROBIN, 1, 1 = round-robin, 0 = fixed priority (m1 wins).
REQ-004 Parameter: TIMEOUT, 16, stalled cycles without ack before abort; legal range 2..255.
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 m0_cyc, m0_stb, m0_we  input  1 each  master 0 (instruction fetch) bus control.
REQ-008 m0_adr  input  AW  master 0 address.
REQ-009 m0_dat_w  input  DW  master 0 write data.
REQ-010 m0_dat_r  output  DW  master 0 read data.
REQ-011 m0_ack, m0_err  output  1 each  master 0 acknowledge / abort.
REQ-012 m1_* (cyc, stb, we, adr, dat_w, dat_r, ack, err): same set as m0_*, master 1 (load/store unit).
REQ-013 s_cyc, s_stb, s_we  output  1 each  shared slave control.
REQ-014 s_adr  output  AW; s_dat_w  output  DW  shared slave address / write data.
REQ-015 s_dat_r  input  DW; s_ack  input  1  slave read data / acknowledge.
REQ-016 gnt  output  2  one-hot current owner (bit0 = m0, bit1 = m1), 2'b00 when idle.

Function
REQ-017 FSM states: IDLE, OWN0, OWN1; state and gnt registered.
REQ-018 IDLE: m0_cyc only -> OWN0 next cycle; m1_cyc only -> OWN1; neither -> stay IDLE.
REQ-019 IDLE, both cyc, ROUND_ROBIN=1: grant the master not granted last (last_owner register); ROUND_ROBIN=0: grant m1.
REQ-020 Grant latency is exactly one cycle from cyc rising in IDLE to gnt bit set; no request is forwarded during the IDLE cycle.
REQ-021 OWNx: held while mx_cyc=1 (bus lock, multi-beat pipelined transfers allowed); mx_cyc=0 -> IDLE next cycle, last_owner <= x.
REQ-022 Ownership never passes directly OWN0 <-> OWN1; at least one IDLE cycle separates owners.
REQ-023 Slave-side mux is combinational from gnt: s_cyc/s_stb/s_we/s_adr/s_dat_w follow the owner; in IDLE s_cyc=s_stb=s_we=0 and s_adr, s_dat_w = 0.
REQ-024 Owner's ack = s_ack & owner's cyc; non-owner ack = 0 at all times; dat_r = s_dat_r for both masters (valid only with ack).
REQ-025 Stall counter: 8-bit; in OWNx increments each cycle mx_stb=1 and s_ack=0; clears on s_ack, on stb=0, and on entering IDLE.
REQ-026 Counter reaching TIMEOUT-1 with no ack: owner's err = 1 for that single cycle, FSM -> IDLE next cycle, s_cyc forced 0 during that IDLE cycle regardless of requests.
REQ-027 After abort, the aborted master is treated as last_owner for arbitration.
REQ-028 s_ack arriving in the same cycle as the timeout condition: ack wins, err stays 0, counter clears.
REQ-029 s_ack while in IDLE is ignored (no master sees ack).
REQ-030 Requester dropping cyc in the same cycle it would be granted: grant still issued; released next cycle per REQ-021.

Reset
REQ-031 rst=1 at a clock edge: state IDLE, gnt=2'b00, counter=0, last_owner=m1 (so m0 wins the first tie), all outputs 0 for the following cycle.
REQ-032 rst asserted mid-transfer aborts ownership silently (no err pulse); slave sees s_cyc=0 from the first cycle after the reset edge.

Verification
REQ-033 m0_cyc=stb=1 adr=0x100, slave acks 1 cycle later with 0xDEADBEEF -> gnt=01 one cycle after request; m0_ack=1, m0_dat_r=0xDEADBEEF; m1_ack=0.
REQ-034 Both cyc rise together after reset, RR=1 -> m0 owns first; m0 drops cyc -> one IDLE cycle -> gnt=10.
REQ-035 RR=0, both request continuously -> m1 granted on every arbitration; m0 granted only while m1_cyc=0.
REQ-036 Owner m1 stb=1, slave never acks, TIMEOUT=16 -> m1_err pulses once on 16th stalled cycle, gnt=00 next cycle, s_cyc=0 that cycle.
REQ-037 m0 performs 4 back-to-back pipelined reads with cyc held while m1 requests -> all 4 acks to m0, m1 granted only after m0 drops cyc plus one IDLE cycle.
REQ-038 rst pulsed while m0 owns and stb=1 -> gnt=00, s_cyc=0, no err on next cycle; re-arbitration after rst deasserts.
